// File: rtl/fifo_rd_sched.sv
// Frame-based read scheduler for the capture FIFO read port: waits for a full
// frame, bursts it out under backpressure, and periodically pulses the read-side reset.
module fifo_rd_sched #(
    parameter int FRAME_LEN      = 500,
    parameter int FRAMES_PER_RST = 4,
    parameter int CNT_W          = 12,
    parameter int RST_LEN        = 4,
    parameter int SETTLE_LEN     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             flush_req,
    input  logic             fifo_empty,
    input  logic [CNT_W-1:0] fifo_rd_count,
    input  logic             dst_ready,
    output logic             fifo_rd_en,
    output logic             fifo_rd_rst,
    output logic             out_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             rst_busy,
    output logic             busy,
    output logic [2:0]       state_dbg
);

    localparam int WORD_W  = $clog2(FRAME_LEN);
    localparam int FRM_W   = $clog2(FRAMES_PER_RST + 1);
    localparam int TMR_MAX = (RST_LEN > SETTLE_LEN) ? RST_LEN : SETTLE_LEN;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [31:0] FRAME_LEN_U = FRAME_LEN;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_READ   = 3'd2,
        S_RESET  = 3'd3,
        S_SETTLE = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [WORD_W-1:0] word_cnt;
    logic [FRM_W-1:0]  frame_cnt;
    logic [TMR_W-1:0]  timer;
    logic              flush_pend;

    logic rd_fire;
    logic last_word;
    logic last_frame;
    logic frame_ready;
    logic rst_timer_done;
    logic settle_timer_done;

    // Reads are gated by fifo_empty too, so a lagging rd_count can never overrun the FIFO.
    assign rd_fire           = (state == S_READ) && dst_ready && !fifo_empty;
    assign last_word         = (word_cnt == WORD_W'(FRAME_LEN - 1));
    assign last_frame        = (frame_cnt == FRM_W'(FRAMES_PER_RST - 1));
    assign frame_ready       = (32'(fifo_rd_count) >= FRAME_LEN_U);
    assign rst_timer_done    = (timer == TMR_W'(RST_LEN - 1));
    assign settle_timer_done = (timer == TMR_W'(SETTLE_LEN - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (flush_req)   state_nxt = S_RESET;
                else if (enable) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (flush_req || flush_pend) state_nxt = S_RESET;
                else if (!enable)            state_nxt = S_IDLE;
                else if (frame_ready)        state_nxt = S_READ;
            end
            S_READ: begin
                // A flush arriving on the last read is honoured the same as a pending one.
                if (rd_fire && last_word)
                    state_nxt = (last_frame || flush_pend || flush_req) ? S_RESET : S_WAIT;
            end
            S_RESET: begin
                if (rst_timer_done) state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_timer_done) state_nxt = enable ? S_WAIT : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            word_cnt    <= '0;
            frame_cnt   <= '0;
            timer       <= '0;
            flush_pend  <= 1'b0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_nxt;
            out_valid   <= rd_fire;
            frame_start <= (state == S_WAIT) && (state_nxt == S_READ);
            frame_done  <= rd_fire && last_word;

            if (rd_fire)
                word_cnt <= last_word ? '0 : word_cnt + 1'b1;

            if (state == S_RESET)
                frame_cnt <= '0;
            else if (rd_fire && last_word)
                frame_cnt <= frame_cnt + 1'b1;

            if ((state != S_RESET) && (state_nxt == S_RESET))
                flush_pend <= 1'b0;
            else if ((state == S_READ) && flush_req)
                flush_pend <= 1'b1;

            // One timer serves both RESET and SETTLE; it restarts on every state change.
            if (state_nxt != state)
                timer <= '0;
            else if ((state == S_RESET) || (state == S_SETTLE))
                timer <= timer + 1'b1;
        end
    end

    assign fifo_rd_en  = rd_fire;
    assign fifo_rd_rst = (state != S_RESET);
    assign rst_busy    = (state == S_RESET) || (state == S_SETTLE);
    assign busy        = (state != S_IDLE);
    assign state_dbg   = state;

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Directed bench for fifo_rd_sched: frame bursts, periodic and flush-driven
// read-side resets, backpressure, count gating and async reset mid-frame.
module tb_fifo_rd_sched;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        flush_req;
    logic        fifo_empty;
    logic [11:0] fifo_rd_count;
    logic        dst_ready;
    logic        fifo_rd_en;
    logic        fifo_rd_rst;
    logic        out_valid;
    logic        frame_start;
    logic        frame_done;
    logic        rst_busy;
    logic        busy;
    logic [2:0]  state_dbg;

    int n_cmp = 0;
    int n_err = 0;
    logic [0:0] exp_q[$];

    fifo_rd_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .flush_req     (flush_req),
        .fifo_empty    (fifo_empty),
        .fifo_rd_count (fifo_rd_count),
        .dst_ready     (dst_ready),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_rst   (fifo_rd_rst),
        .out_valid     (out_valid),
        .frame_start   (frame_start),
        .frame_done    (frame_done),
        .rst_busy      (rst_busy),
        .busy          (busy),
        .state_dbg     (state_dbg)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one frame from the current point. t_start is the loop index of the
    // frame_start pulse, t_len the cycles from frame_start to frame_done (-1 on timeout).
    task automatic run_frame(input bit toggle, input int flush_at, input int en_off_at,
                             output int nrd, output int t_start, output int t_len);
        bit started;
        bit flushed;
        logic [0:0] e;
        nrd = 0; t_start = -1; t_len = -1;
        started = 0; flushed = 0;
        exp_q.delete();
        for (int c = 0; c < 5000; c++) begin
            if (toggle) begin
                dst_ready  = c[0];
                fifo_empty = (c >= 300) && (c < 310);
            end
            flush_req = 1'b0;
            if (flush_at >= 0 && started && !flushed && nrd == flush_at) begin
                flush_req = 1'b1;
                flushed   = 1;
            end
            if (en_off_at >= 0 && started && nrd >= en_off_at)
                enable = 1'b0;
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_valid_lag", 32'(out_valid), 32'(e));
            end
            exp_q.push_back(fifo_rd_en);
            chk("rd_en_legal", 32'(fifo_rd_en && (fifo_empty || !dst_ready)), 0);
            if (frame_start && !started) begin
                started = 1;
                t_start = c;
            end
            if (started && fifo_rd_en) nrd++;
            if (started && frame_done) begin
                t_len = c - t_start;
                break;
            end
            @(posedge clk);
            #1;
        end
        flush_req = 1'b0;
    endtask

    task automatic measure_reset(output int nlow, output int nbusy);
        nlow = 0; nbusy = 0;
        for (int i = 0; i < 100; i++) begin
            if (!rst_busy) break;
            nbusy++;
            if (!fifo_rd_rst) nlow++;
            @(negedge clk);
        end
    endtask

    initial begin
        int nrd, t_start, t_len, nlow, nbusy, n;
        bit started;

        rst_n = 1'b0; enable = 1'b0; flush_req = 1'b0; fifo_empty = 1'b0;
        fifo_rd_count = 12'd500; dst_ready = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_rd_en", 32'(fifo_rd_en), 0);
        chk("rst_rd_rst", 32'(fifo_rd_rst), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_frame_start", 32'(frame_start), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_rst_busy", 32'(rst_busy), 0);
        chk("rst_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single frame, no backpressure
        enable = 1'b1;
        run_frame(0, -1, -1, nrd, t_start, t_len);
        chk("f1_start_lat", t_start, 2);
        chk("f1_words", nrd, 500);
        chk("f1_len", t_len, 500);
        chk("f1_no_reset", 32'(rst_busy), 0);

        // frames 2..8: automatic reset after frames 4 and 8
        for (int f = 2; f <= 8; f++) begin
            run_frame(0, -1, -1, nrd, t_start, t_len);
            chk("fN_start_lat", t_start, 0);
            chk("fN_words", nrd, 500);
            chk("fN_len", t_len, 500);
            chk("fN_reset_due", 32'(rst_busy), 32'(f == 4 || f == 8));
            if (f == 4 || f == 8) begin
                measure_reset(nlow, nbusy);
                chk("auto_rst_low", nlow, 4);
                chk("auto_rst_busy", nbusy, 12);
            end
        end

        // backpressure toggling and empty pulse mid-frame
        run_frame(1, -1, -1, nrd, t_start, t_len);
        chk("bp_start_lat", t_start, 0);
        chk("bp_words", nrd, 500);
        chk("bp_len", t_len, 1010);
        chk("bp_no_reset", 32'(rst_busy), 0);
        dst_ready = 1'b1; fifo_empty = 1'b0;

        // flush at word 100 completes the frame, then resets into IDLE
        run_frame(0, 100, -1, nrd, t_start, t_len);
        chk("fl_words", nrd, 500);
        chk("fl_len", t_len, 500);
        chk("fl_reset", 32'(rst_busy), 1);
        enable = 1'b0;
        measure_reset(nlow, nbusy);
        chk("fl_rst_low", nlow, 4);
        chk("fl_rst_busy", nbusy, 12);
        chk("fl_idle", 32'(busy), 0);

        // flush in IDLE
        @(posedge clk); #1;
        flush_req = 1'b1;
        @(negedge clk);
        chk("idle_fl_pre", 32'(fifo_rd_rst), 1);
        @(posedge clk); #1;
        flush_req = 1'b0;
        @(negedge clk);
        chk("idle_fl_next", 32'(fifo_rd_rst), 0);
        measure_reset(nlow, nbusy);
        chk("idle_fl_low", nlow, 4);
        chk("idle_fl_busy", nbusy, 12);
        chk("idle_fl_back", 32'(busy), 0);

        // count one short of a frame holds in WAIT_DATA
        fifo_rd_count = 12'd499;
        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_rd_en", 32'(fifo_rd_en), 0);
        end
        chk("hold_state", 32'(state_dbg), 1);
        chk("hold_no_start", 32'(frame_start), 0);
        fifo_rd_count = 12'd500;
        run_frame(0, -1, 250, nrd, t_start, t_len);
        chk("en_off_start", t_start, 0);
        chk("en_off_words", nrd, 500);
        chk("en_off_len", t_len, 500);
        chk("en_off_no_reset", 32'(rst_busy), 0);
        @(negedge clk);
        chk("en_off_idle", 32'(busy), 0);

        // async reset at word 300
        enable = 1'b1;
        n = 0; started = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (frame_start) started = 1;
            if (started && fifo_rd_en) n++;
            if (n == 300) break;
        end
        chk("ar_reached", n, 300);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_rd_en", 32'(fifo_rd_en), 0);
        chk("ar_rd_rst", 32'(fifo_rd_rst), 1);
        chk("ar_out_valid", 32'(out_valid), 0);
        chk("ar_frame_start", 32'(frame_start), 0);
        chk("ar_frame_done", 32'(frame_done), 0);
        chk("ar_rst_busy", 32'(rst_busy), 0);
        chk("ar_busy", 32'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_frame(0, -1, -1, nrd, t_start, t_len);
        chk("ar_fresh_start", t_start, 2);
        chk("ar_fresh_words", nrd, 500);
        chk("ar_fresh_len", t_len, 500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
